// File: rtl/multicycle_ctrl_if.sv
// Handshake/control bundle between multicycle_ctrl (master) and the IR/datapath/memories (slave).
// MULTICYCLE_CTRL_PERF_EN adds the instret and cycle_cnt counter outputs.
interface multicycle_ctrl_if;
    logic [31:0] inst;
    logic        br_taken;
    logic        if_ack;
    logic        dmem_ack;
    logic        if_req;
    logic        ir_we;
    logic [2:0]  sext_op;
    logic        alu_b_sel;
    logic        dmem_re;
    logic        dmem_we;
    logic        rf_we;
    logic [1:0]  wd_sel;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic        trap;
    logic [2:0]  state;
`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] instret;
    logic [31:0] cycle_cnt;
`endif

    modport master (
        input  inst, br_taken, if_ack, dmem_ack,
        output if_req, ir_we, sext_op, alu_b_sel, dmem_re, dmem_we,
               rf_we, wd_sel, pc_we, pc_sel, trap, state
`ifdef MULTICYCLE_CTRL_PERF_EN
        , output instret, cycle_cnt
`endif
    );

    modport slave (
        output inst, br_taken, if_ack, dmem_ack,
        input  if_req, ir_we, sext_op, alu_b_sel, dmem_re, dmem_we,
               rf_we, wd_sel, pc_we, pc_sel, trap, state
`ifdef MULTICYCLE_CTRL_PERF_EN
        , input instret, cycle_cnt
`endif
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM with memory-ack timeout and sticky trap.
// Define MULTICYCLE_CTRL_PERF_EN to add the instret / cycle_cnt performance counters.
module multicycle_ctrl #(
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    multicycle_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, TRAP = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        CL_ALU = 3'd0, CL_LOAD = 3'd1, CL_STORE = 3'd2, CL_BRANCH = 3'd3,
        CL_LUI = 3'd4, CL_JAL = 3'd5, CL_JALR = 3'd6
    } class_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t     state_reg;
    class_t     class_reg;
    logic [2:0] sext_reg;
    logic       b_sel_reg;
    logic [1:0] wd_sel_reg;
    logic [7:0] wait_cnt_reg;

    class_t     dec_class;
    logic       dec_legal;
    logic [2:0] dec_sext;
    logic       dec_b_sel;
    logic [1:0] dec_wd_sel;
    logic [2:0] funct3;
    logic [7:0] wait_cnt_inc;
    logic       timed_out;
    logic       unused_inst_bits;

    assign funct3           = bus.inst[14:12];
    assign unused_inst_bits = ^{bus.inst[31:15], bus.inst[11:7]};
    assign wait_cnt_inc     = wait_cnt_reg + 8'd1;
    // Only consulted when no ack arrived this cycle, so a same-cycle ack always wins.
    assign timed_out        = (wait_cnt_inc == TIMEOUT_CNT);

    always_comb begin
        dec_legal  = 1'b1;
        dec_class  = CL_ALU;
        dec_sext   = 3'b000;
        dec_b_sel  = 1'b0;
        dec_wd_sel = 2'b00;
        case (bus.inst[6:0])
            7'b0110011: ;
            7'b0010011: begin
                dec_sext  = (funct3 == 3'b001 || funct3 == 3'b101) ? 3'b001 : 3'b000;
                dec_b_sel = 1'b1;
            end
            7'b0000011: begin dec_class = CL_LOAD;   dec_b_sel = 1'b1; dec_wd_sel = 2'b01; end
            7'b0100011: begin dec_class = CL_STORE;  dec_sext = 3'b010; dec_b_sel = 1'b1; end
            7'b1100011: begin dec_class = CL_BRANCH; dec_sext = 3'b011; end
            7'b0110111: begin dec_class = CL_LUI;    dec_sext = 3'b100; dec_wd_sel = 2'b11; end
            7'b1101111: begin dec_class = CL_JAL;    dec_sext = 3'b101; dec_wd_sel = 2'b10; end
            7'b1100111: begin dec_class = CL_JALR;   dec_b_sel = 1'b1; dec_wd_sel = 2'b10; end
            default:    dec_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= FETCH;
            class_reg    <= CL_ALU;
            sext_reg     <= 3'b000;
            b_sel_reg    <= 1'b0;
            wd_sel_reg   <= 2'b00;
            wait_cnt_reg <= 8'd0;
        end else begin
            case (state_reg)
                FETCH: begin
                    if (bus.if_ack) begin
                        state_reg    <= DECODE;
                        wait_cnt_reg <= 8'd0;
                    end else if (timed_out) begin
                        state_reg    <= TRAP;
                        wait_cnt_reg <= 8'd0;
                    end else begin
                        wait_cnt_reg <= wait_cnt_inc;
                    end
                end
                DECODE: begin
                    if (dec_legal) begin
                        state_reg  <= EXEC;
                        class_reg  <= dec_class;
                        sext_reg   <= dec_sext;
                        b_sel_reg  <= dec_b_sel;
                        wd_sel_reg <= dec_wd_sel;
                    end else begin
                        state_reg <= TRAP;
                    end
                end
                EXEC: begin
                    if (class_reg == CL_BRANCH) begin
                        state_reg <= FETCH;
                    end else if (class_reg == CL_LOAD || class_reg == CL_STORE) begin
                        state_reg <= MEM;
                    end else begin
                        state_reg <= WB;
                    end
                end
                MEM: begin
                    if (bus.dmem_ack) begin
                        wait_cnt_reg <= 8'd0;
                        if (class_reg == CL_LOAD) begin
                            state_reg <= WB;
                        end else begin
                            state_reg <= FETCH;
                        end
                    end else if (timed_out) begin
                        state_reg    <= TRAP;
                        wait_cnt_reg <= 8'd0;
                    end else begin
                        wait_cnt_reg <= wait_cnt_inc;
                    end
                end
                WB:      state_reg <= FETCH;
                default: state_reg <= TRAP;
            endcase
        end
    end

    logic       if_req, ir_we, dmem_re, dmem_we, rf_we, pc_we, trap;
    logic [1:0] pc_sel;

    // Gating with rst_n makes every request drop the instant reset asserts.
    always_comb begin
        if_req  = 1'b0;
        ir_we   = 1'b0;
        dmem_re = 1'b0;
        dmem_we = 1'b0;
        rf_we   = 1'b0;
        pc_we   = 1'b0;
        pc_sel  = 2'b00;
        trap    = 1'b0;
        case (state_reg)
            FETCH: begin
                if_req = 1'b1;
                ir_we  = bus.if_ack;
            end
            EXEC: begin
                if (class_reg == CL_BRANCH) begin
                    pc_we  = 1'b1;
                    pc_sel = bus.br_taken ? 2'b01 : 2'b00;
                end
            end
            MEM: begin
                dmem_re = (class_reg == CL_LOAD);
                dmem_we = (class_reg == CL_STORE);
                pc_we   = (class_reg == CL_STORE) && bus.dmem_ack;
            end
            WB: begin
                rf_we = 1'b1;
                pc_we = 1'b1;
                if (class_reg == CL_JAL) begin
                    pc_sel = 2'b01;
                end else if (class_reg == CL_JALR) begin
                    pc_sel = 2'b10;
                end
            end
            TRAP:    trap = 1'b1;
            default: ;
        endcase
        if (!rst_n) begin
            if_req  = 1'b0;
            ir_we   = 1'b0;
            dmem_re = 1'b0;
            dmem_we = 1'b0;
            rf_we   = 1'b0;
            pc_we   = 1'b0;
            pc_sel  = 2'b00;
            trap    = 1'b0;
        end
    end

    assign bus.if_req    = if_req;
    assign bus.ir_we     = ir_we;
    assign bus.dmem_re   = dmem_re;
    assign bus.dmem_we   = dmem_we;
    assign bus.rf_we     = rf_we;
    assign bus.pc_we     = pc_we;
    assign bus.pc_sel    = pc_sel;
    assign bus.trap      = trap;
    assign bus.sext_op   = sext_reg;
    assign bus.alu_b_sel = b_sel_reg;
    assign bus.wd_sel    = wd_sel_reg;
    assign bus.state     = state_reg;

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] instret_reg;
    logic [31:0] cycle_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret_reg   <= 32'd0;
            cycle_cnt_reg <= 32'd0;
        end else if (state_reg != TRAP) begin
            cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
            if (pc_we) begin
                instret_reg <= instret_reg + 32'd1;
            end
        end
    end

    assign bus.instret   = instret_reg;
    assign bus.cycle_cnt = cycle_cnt_reg;
`endif
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: a transaction-level model expands each instruction into
// its expected per-cycle control trace, checked every cycle, plus hand-computed literal checks.
module tb_multicycle_ctrl;
    localparam int TO = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multicycle_ctrl_if bus();
    multicycle_ctrl #(.TIMEOUT(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef enum logic [2:0] {K_ALU, K_LOAD, K_STORE, K_BR, K_LUI, K_JAL, K_JALR, K_ILL} kind_t;
    typedef struct packed {
        kind_t      kind;
        logic [2:0] sext;
        logic       b_sel;
        logic [1:0] wd;
    } spec_t;
    typedef struct packed {
        logic [2:0] state;
        logic       if_req, ir_we, dmem_re, dmem_we, rf_we, pc_we;
        logic [1:0] pc_sel;
        logic       trap;
    } ctl_t;
    typedef struct packed {
        ctl_t       ctl;
        logic       imm_chk;
        logic [2:0] sext;
        logic       b_sel;
        logic [1:0] wd;
    } exp_t;

    exp_t  exp_q[$];
    exp_t  cur_e;
    ctl_t  act_c;
    logic [5:0] cur_imm;
    spec_t held;
    logic  held_valid = 1'b0;
    int    n_tests = 0, n_fail = 0;
    int    n_pc_we = 0, n_rf_we = 0, n_dmem_we = 0;
    int    s_pc, s_rf, s_dw;

    assign act_c = {bus.state, bus.if_req, bus.ir_we, bus.dmem_re, bus.dmem_we,
                    bus.rf_we, bus.pc_we, bus.pc_sel, bus.trap};

    // Instruction-class table straight from the opcode rules.
    function automatic spec_t spec_decode(input logic [31:0] ins);
        spec_t d;
        logic [2:0] f3;
        d = '0;
        f3 = ins[14:12];
        case (ins[6:0])
            7'h33: d = '{K_ALU, 3'b000, 1'b0, 2'b00};
            7'h13: d = '{K_ALU, (f3 == 3'd1 || f3 == 3'd5) ? 3'b001 : 3'b000, 1'b1, 2'b00};
            7'h03: d = '{K_LOAD, 3'b000, 1'b1, 2'b01};
            7'h23: d = '{K_STORE, 3'b010, 1'b1, 2'b00};
            7'h63: d = '{K_BR, 3'b011, 1'b0, 2'b00};
            7'h37: d = '{K_LUI, 3'b100, 1'b0, 2'b11};
            7'h6F: d = '{K_JAL, 3'b101, 1'b0, 2'b10};
            7'h67: d = '{K_JALR, 3'b000, 1'b1, 2'b10};
            default: d.kind = K_ILL;
        endcase
        return d;
    endfunction

    function automatic exp_t base(input logic [2:0] st);
        exp_t e;
        e = '0;
        e.ctl.state = st;
        e.imm_chk   = held_valid;
        e.sext      = held.sext;
        e.b_sel     = held.b_sel;
        e.wd        = held.wd;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Entered and left at 1 time unit after a rising edge; expectation applies to this cycle.
    task automatic step(input exp_t e, input logic ia, input logic da, input logic br);
        bus.if_ack   = ia;
        bus.dmem_ack = da;
        bus.br_taken = br;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        bus.if_ack   = 1'b0;
        bus.dmem_ack = 1'b0;
        bus.br_taken = 1'b0;
    endtask

    task automatic trap_cycles(input int n);
        exp_t e;
        e = base(3'd7);
        e.ctl.trap = 1'b1;
        for (int k = 0; k < n; k++) step(e, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic run_instr(input logic [31:0] ins, input int fw, input int mw,
                             input logic br, input logic abort);
        spec_t d;
        exp_t  e;
        d = spec_decode(ins);
        $display("[TB] txn inst=%08h fetch_wait=%0d mem_wait=%0d br=%0b abort=%0b",
                 ins, fw, mw, br, abort);
        bus.inst = 32'hFFFF_FFFF;
        e = base(3'd0);
        e.ctl.if_req = 1'b1;
        if (fw >= TO) begin
            for (int k = 0; k < TO; k++) step(e, 1'b0, 1'b0, 1'b0);
            trap_cycles(3);
            return;
        end
        for (int k = 0; k < fw; k++) step(e, 1'b0, 1'b0, 1'b0);
        e.ctl.ir_we = 1'b1;
        step(e, 1'b1, 1'b0, 1'b0);
        bus.inst = ins;
        step(base(3'd1), 1'b0, 1'b0, 1'b0);
        bus.inst = 32'hFFFF_FFFF;
        if (d.kind == K_ILL) begin
            held_valid = 1'b0;
            trap_cycles(20);
            return;
        end
        held = d;
        e = base(3'd2);
        if (d.kind == K_BR) begin
            e.ctl.pc_we  = 1'b1;
            e.ctl.pc_sel = br ? 2'b01 : 2'b00;
            step(e, 1'b0, 1'b0, br);
            return;
        end
        step(e, 1'b0, 1'b0, 1'b0);
        if (d.kind == K_LOAD || d.kind == K_STORE) begin
            e = base(3'd3);
            e.ctl.dmem_re = (d.kind == K_LOAD);
            e.ctl.dmem_we = (d.kind == K_STORE);
            for (int k = 0; k < ((mw >= TO) ? TO : mw); k++) step(e, 1'b0, 1'b0, 1'b0);
            if (mw >= TO) begin
                trap_cycles(3);
                return;
            end
            if (abort) return;
            e.ctl.pc_we = (d.kind == K_STORE);
            step(e, 1'b0, 1'b1, 1'b0);
            if (d.kind == K_STORE) return;
        end
        e = base(3'd4);
        e.ctl.rf_we  = 1'b1;
        e.ctl.pc_we  = 1'b1;
        e.ctl.pc_sel = (d.kind == K_JAL) ? 2'b01 : ((d.kind == K_JALR) ? 2'b10 : 2'b00);
        step(e, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        #6;
        rst_n = 1'b0;
        #1;
        check("rst_outputs", 32'({bus.if_req, bus.ir_we, bus.sext_op, bus.alu_b_sel, bus.dmem_re,
                                  bus.dmem_we, bus.rf_we, bus.wd_sel, bus.pc_we, bus.pc_sel,
                                  bus.trap, bus.state}), 32'd0);
        held       = '0;
        held_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic snap();
        s_pc = n_pc_we;
        s_rf = n_rf_we;
        s_dw = n_dmem_we;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.pc_we) n_pc_we++;
                if (bus.rf_we) n_rf_we++;
                if (bus.dmem_we) n_dmem_we++;
            end
            if (exp_q.size() > 0) begin
                cur_e   = exp_q.pop_front();
                cur_imm = {bus.sext_op, bus.alu_b_sel, bus.wd_sel};
                n_tests++;
                if (act_c !== cur_e.ctl ||
                    (cur_e.imm_chk && cur_imm !== {cur_e.sext, cur_e.b_sel, cur_e.wd})) begin
                    n_fail++;
                    $display("FAIL cycle_check @%0t: got ctl=%03h imm=%02h, expected ctl=%03h imm=%02h",
                             $time, act_c, cur_imm, cur_e.ctl, {cur_e.sext, cur_e.b_sel, cur_e.wd});
                end
            end
        end
    end

    initial begin
        bus.inst     = 32'hFFFF_FFFF;
        bus.if_ack   = 1'b0;
        bus.dmem_ack = 1'b0;
        bus.br_taken = 1'b0;
        held         = '0;
        do_reset();
`ifdef MULTICYCLE_CTRL_PERF_EN
        check("instret_after_reset", bus.instret, 32'd0);
`endif
        snap();
        run_instr(32'h00500093, 0, 0, 1'b0, 1'b0);
        check("addi_sext", 32'(bus.sext_op), 32'd0);
        check("addi_bsel", 32'(bus.alu_b_sel), 32'd1);
        check("addi_rf_we_pulses", 32'(n_rf_we - s_rf), 32'd1);
        check("addi_pc_we_pulses", 32'(n_pc_we - s_pc), 32'd1);

        run_instr(32'h00209093, 2, 0, 1'b0, 1'b0);
        check("slli_sext", 32'(bus.sext_op), 32'd1);

        snap();
        run_instr(32'h0020A023, 1, 4, 1'b0, 1'b0);
        check("sw_dmem_we_cycles", 32'(n_dmem_we - s_dw), 32'd5);
        check("sw_rf_we_pulses", 32'(n_rf_we - s_rf), 32'd0);
        check("sw_pc_we_pulses", 32'(n_pc_we - s_pc), 32'd1);
`ifdef MULTICYCLE_CTRL_PERF_EN
        check("instret_after_3", bus.instret, 32'd3);
`endif

        snap();
        run_instr(32'h00000463, 0, 0, 1'b1, 1'b0);
        check("beq_sext", 32'(bus.sext_op), 32'd3);
        check("beq_pc_we_pulses", 32'(n_pc_we - s_pc), 32'd1);
        run_instr(32'h00000463, 1, 0, 1'b0, 1'b0);
        run_instr(32'h0000A083, 0, 2, 1'b0, 1'b0);
        run_instr(32'h0080006F, 0, 0, 1'b0, 1'b0);
        check("jal_sext", 32'(bus.sext_op), 32'd5);
        check("jal_wd_sel", 32'(bus.wd_sel), 32'd2);
        run_instr(32'h000080E7, 0, 0, 1'b0, 1'b0);
        run_instr(32'h123450B7, 0, 0, 1'b0, 1'b0);
        check("lui_sext", 32'(bus.sext_op), 32'd4);
        check("lui_wd_sel", 32'(bus.wd_sel), 32'd3);
        run_instr(32'h002081B3, 3, 0, 1'b0, 1'b0);

        run_instr(32'h00500093, TO - 1, 0, 1'b0, 1'b0);
        check("ack_on_15_no_trap", 32'(bus.trap), 32'd0);

        run_instr(32'h0000007F, 0, 0, 1'b0, 1'b0);
        check("illegal_trap_sticky", 32'(bus.trap), 32'd1);
        do_reset();

        run_instr(32'h00500093, TO, 0, 1'b0, 1'b0);
        check("fetch_timeout_state", 32'(bus.state), 32'd7);
        do_reset();

        run_instr(32'h0000A083, 0, 3, 1'b0, 1'b1);
        check("pre_rst_dmem_re", 32'(bus.dmem_re), 32'd1);
        do_reset();
`ifdef MULTICYCLE_CTRL_PERF_EN
        check("instret_after_mid_reset", bus.instret, 32'd0);
`endif
        run_instr(32'h00500093, 0, 0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
